// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 8.8 fixed-point multiplier among
// NUM_REQ requesters, one outstanding operation at a time.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [WIDTH-1:0]         mul_out,
  output logic [31:0]              op_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt;
  logic [PW-1:0]    pick;
  logic             found;
  logic             accept;
  logic             hs;
  int               idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] data_q;
  logic [31:0]      cnt;

  // First pending request at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hs       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (resp_ready[gnt]) begin
          hs       = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]  = accept && (pick == PW'(i));
      resp_valid[i] = (state == RESP) && (gnt == PW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        gnt  <= pick;
        op_a <= req_a[int'(pick)*WIDTH +: WIDTH];
        op_b <= req_b[int'(pick)*WIDTH +: WIDTH];
      end
      if (state == EXEC) begin
        data_q <= mul_out;
      end
      // Pointer moves past the winner only once its result is taken.
      if (hs) begin
        rr_ptr <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + PW'(1);
        cnt    <= cnt + 32'd1;
      end
    end
  end

  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign resp_data = data_q;
  assign op_count  = cnt;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural
// 8.8 multiplier standing in for the shared Multiplier.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [15:0] resp_data;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_out;
  logic [31:0] op_count;
  logic [31:0] prod;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign prod    = {16'h0, mul_a} * {16'h0, mul_b};
  assign mul_out = prod[23:8];

  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_out    (mul_out),
    .op_count   (op_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r,
                         input logic [15:0] a,
                         input logic [15:0] b);
    req_a[r*16 +: 16] = a;
    req_b[r*16 +: 16] = b;
  endtask

  // Starts and ends at a negedge with the arbiter idle.
  task automatic do_op(input int r,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] exp);
    int w;
    logic [3:0] oh;
    oh = 4'(1 << r);
    step();
    set_req(r, a, b);
    req_valid = oh;
    @(negedge clk);
    w = 0;
    while (req_ready != oh && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("sweep_acc", req_ready, oh);
    step();
    req_valid = '0;
    @(negedge clk);
    w = 0;
    while (resp_valid != oh && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("sweep_vld", resp_valid, oh);
    check("sweep_data", resp_data, exp);
    resp_ready = oh;
    step();
    resp_ready = '0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  e;
    logic [15:0] ek;
    int          kk;

    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 4'b0);
    check("rst_resp_valid", resp_valid, 4'b0);
    check("rst_resp_data", resp_data, 16'h0);
    check("rst_mul_a", mul_a, 16'h0);
    check("rst_mul_b", mul_b, 16'h0);
    check("rst_op_count", op_count, 32'd0);
    step();
    rst_n = 1'b1;

    // single op: 3.0 * 4.0
    set_req(1, 16'h0300, 16'h0400);
    req_valid = 4'b0010;
    @(negedge clk);
    check("single_rdy", req_ready, 4'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    check("exec_mul_a", mul_a, 16'h0300);
    check("exec_mul_b", mul_b, 16'h0400);
    check("exec_vld", resp_valid, 4'b0);
    step();
    @(negedge clk);
    check("single_vld", resp_valid, 4'b0010);
    check("single_data", resp_data, 16'h0c00);
    resp_ready = 4'b0010;
    step();
    resp_ready = '0;
    @(negedge clk);
    check("single_cnt", op_count, 32'd1);
    check("single_idle_vld", resp_valid, 4'b0);

    // reset while in RESP
    step();
    set_req(1, 16'h0500, 16'h0200);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("rst_pre_vld", resp_valid, 4'b0010);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", resp_valid, 4'b0);
    check("mid_rst_rdy", req_ready, 4'b0);
    check("mid_rst_data", resp_data, 16'h0);
    check("mid_rst_mul_a", mul_a, 16'h0);
    check("mid_rst_mul_b", mul_b, 16'h0);
    check("mid_rst_cnt", op_count, 32'd0);
    resp_ready = 4'b1111;
    repeat (3) begin
      step();
      @(negedge clk);
      check("mid_rst_no_vld", resp_valid, 4'b0);
    end
    check("mid_rst_cnt2", op_count, 32'd0);

    // contention: all request, responses always accepted
    step();
    set_req(0, 16'h0100, 16'h0100);
    set_req(1, 16'h0200, 16'h0100);
    set_req(2, 16'h0300, 16'h0100);
    set_req(3, 16'h0400, 16'h0100);
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      e = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0;
      check("cont_rdy", req_ready, e);
      if (c % 3 == 2) begin
        check("cont_data", resp_data, 16'(((c / 3) % 4 + 1) << 8));
      end
      if (c % 3 == 0) begin
        check("cont_cnt", op_count, 32'(c / 3));
      end
      step();
    end
    req_valid  = '0;
    resp_ready = '0;
    @(negedge clk);
    check("cont_cnt_end", op_count, 32'd5);

    // fairness and pointer wrap
    step();
    set_req(3, 16'h0200, 16'h0200);
    req_valid = 4'b1000;
    @(negedge clk);
    check("fair_g3", req_ready, 4'b1000);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("fair_d3", resp_data, 16'h0400);
    resp_ready = 4'b1000;
    step();
    resp_ready = '0;
    set_req(0, 16'h0100, 16'h0300);
    set_req(2, 16'h0300, 16'h0300);
    req_valid = 4'b0101;
    @(negedge clk);
    check("fair_wrap", req_ready, 4'b0001);
    step();
    req_valid = 4'b0100;
    step();
    @(negedge clk);
    check("fair_norq", req_ready, 4'b0);
    check("fair_d0", resp_data, 16'h0300);
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    @(negedge clk);
    check("fair_g2", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("fair_d2", resp_data, 16'h0900);
    resp_ready = 4'b0100;
    step();
    resp_ready = '0;
    @(negedge clk);
    check("fair_cnt", op_count, 32'd8);

    // backpressure on requester 2 with requester 0 waiting
    step();
    set_req(2, 16'h0100, 16'hff00);
    req_valid = 4'b0100;
    @(negedge clk);
    check("bp_g2", req_ready, 4'b0100);
    step();
    set_req(0, 16'h0200, 16'h0080);
    req_valid = 4'b0001;
    @(negedge clk);
    check("bp_exec_rdy", req_ready, 4'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("bp_vld", resp_valid, 4'b0100);
      check("bp_data", resp_data, 16'hff00);
      check("bp_rdy", req_ready, 4'b0);
    end
    step();
    resp_ready = 4'b0100;
    @(negedge clk);
    check("bp_hs_vld", resp_valid, 4'b0100);
    check("bp_hs_rdy", req_ready, 4'b0);
    step();
    resp_ready = '0;
    @(negedge clk);
    check("bp_after", req_ready, 4'b0001);
    check("bp_cnt", op_count, 32'd9);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("bp_d0_vld", resp_valid, 4'b0001);
    check("bp_d0", resp_data, 16'h0100);
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    @(negedge clk);
    check("bp_cnt2", op_count, 32'd10);

    // sweep a=b=k<<8 rotating through requesters
    for (int k = 0; k < 256; k++) begin
      kk = k * k;
      ek = {kk[7:0], 8'h00};
      do_op(k % 4, 16'(k << 8), 16'(k << 8), ek);
    end
    check("sweep_cnt", op_count, 32'd266);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 16-bit 8.8 fixed-point `Multiplier` instance among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, drives the multiplier operands from registers, captures the product and returns it to the granted requester with a valid/ready response handshake. It sits between the datapath clients and the single `Multiplier` instance; only one operation is outstanding at a time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width; must match `Multiplier`
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_ready  output  NUM_REQ  one-hot accept pulse
- req_a  input  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a
- resp_valid  output  NUM_REQ  one-hot result valid
- resp_ready  input  NUM_REQ  per-requester result accept
- resp_data  output  WIDTH  product, shared by all requesters
- mul_a  output  WIDTH  to `Multiplier.a`
- mul_b  output  WIDTH  to `Multiplier.b`
- mul_out  input  WIDTH  from `Multiplier.out`, combinational in mul_a/mul_b
- op_count  output  32  completed operations, wraps 0xFFFF_FFFF -> 0

## Operation
- States: IDLE, EXEC, RESP. Encoding is free.
- IDLE, any req_valid set:
  - Grant the first set index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Assert req_ready[grant] for exactly this cycle.
  - Latch req_a/req_b slices into op_a/op_b and grant into gnt.
  - Go to EXEC.
- IDLE, no req_valid: stay in IDLE; req_ready = 0.
- EXEC:
  - mul_a = op_a and mul_b = op_b; these registers also hold in all other states.
  - Register mul_out into resp_data.
  - Go to RESP.
- RESP:
  - resp_valid[gnt] = 1; all other bits are 0.
  - Hold resp_data and gnt stable until resp_ready[gnt] is sampled high.
  - On that handshake: rr_ptr <= (gnt+1) mod NUM_REQ, op_count += 1, go to IDLE.
  - resp_ready on non-granted bits is ignored.
- Arithmetic is entirely inside `Multiplier`; the arbiter passes bits unmodified and never truncates or extends.
- A requester must hold req_valid/req_a/req_b until its req_ready pulse. Dropping req_valid before grant withdraws the request without error.
- A requester may re-request while its response is pending. It is not accepted until the FSM returns to IDLE.

## Timing
- Reset (rst_n low at an edge) values:
  - State IDLE, rr_ptr 0, gnt 0.
  - req_ready 0, resp_valid 0, resp_data 0.
  - mul_a 0, mul_b 0, op_a 0, op_b 0, op_count 0.
- Reset mid-operation (EXEC or RESP) aborts the operation silently:
  - No resp_valid is produced and op_count is not incremented.
  - Requests outstanding after reset are re-arbitrated from rr_ptr = 0.
- Latency:
  - Accept at cycle T (req_ready high).
  - resp_valid high from cycle T+2.
  - If resp_ready is already high at T+2, IDLE at T+3 and the next accept at T+3.
- Minimum issue interval is 3 cycles.
- req_ready is never asserted outside IDLE and is never high for two consecutive cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others keep waiting.
- rr_ptr wraps NUM_REQ-1 -> 0.
- The rr_ptr update and the IDLE transition both happen on the response handshake edge.

## Test plan
- **Single op:** req_valid[1] with a=0x0300, b=0x0400 at T.
  - req_ready = 0b0010 at T.
  - resp_valid = 0b0010 and resp_data = 0x0C00 at T+2.
  - resp_ready[1] high -> op_count = 1.
- **Contention:** all four req_valid held high, resp_ready tied high.
  - Grants in order 0,1,2,3,0, spaced 3 cycles apart.
  - op_count increments by 1 on each handshake.
- **Fairness / wrap:**
  - Complete an op on requester 3, then assert req_valid[0] and req_valid[2] together -> grant 0 (rr_ptr wrapped to 0).
  - Then grant 2.
- **Backpressure:** op 0x0100*0xFF00 on requester 2, resp_ready[2] held low 5 cycles.
  - resp_data stays 0xFF00 and resp_valid stays 0b0100 throughout.
  - No req_ready while req_valid[0] is also high.
  - Requester 0 is accepted only after the handshake.
- **Reset mid-op:** drop rst_n for one edge while in RESP.
  - All outputs read 0 on the next cycle; resp_valid never returns for the aborted op.
  - op_count is unchanged (0).
- **Full sweep:** requester i issues a=b=k<<8 for k=0..255 through the real `Multiplier` instance.
  - Each resp_data equals mul_out for the same operands, captured at EXEC.
  - Response order matches issue order.
